// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction fetch stage. Holds the fetch PC, issues single-word reads to
// instruction memory over a req/gnt/rvalid handshake (one outstanding read at
// most), and hands each instruction with its PC to decode through a
// registered instruction register. A one-entry skid buffer catches a response
// that lands while decode is stalled. A redirect flushes everything buffered
// and drains any read still in flight.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req / imem_addr       read request and its word address (= fetch_pc)
//   imem_gnt                   request accepted this cycle
//   imem_rvalid / imem_rdata   read response
//   stall                      decode cannot accept; ir holds
//   redirect / redirect_pc     taken branch/jump: flush and refetch
//   ir / ir_pc / ir_valid      instruction register toward decode
//   perf_fetched, perf_stall   consume and stall-cycle counters
//                              (only when IF_PERF_CNT_EN is defined)
//
// State | meaning
// FETCH | no read outstanding; request when skid empty and no redirect
// WAIT  | read granted, waiting for its response
// DRAIN | read outstanding from before a redirect; its data is discarded

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] skid;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic        grant;
    logic        consume;
    logic        resp_take;

    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign consume   = ir_valid && !stall;
    // A response in WAIT is kept unless a redirect in the same cycle kills it.
    assign resp_take = (state == ST_WAIT) && imem_rvalid && !redirect;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            ST_FETCH: begin
                // rst_n gating keeps the request low while reset is held.
                imem_req = rst_n && !skid_valid && !redirect;
                if (imem_req && imem_gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? ST_FETCH : ST_DRAIN;
                end else if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            pend_pc  <= 32'd0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (grant) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= 32'd0;
            ir_pc      <= 32'd0;
            ir_valid   <= 1'b0;
            skid       <= 32'd0;
            skid_pc    <= 32'd0;
            skid_valid <= 1'b0;
        end else if (redirect) begin
            ir_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                ir       <= skid;
                ir_pc    <= skid_pc;
                ir_valid <= 1'b1;
                // Skid stays occupied only if a new response refills it.
                if (resp_take) begin
                    skid    <= imem_rdata;
                    skid_pc <= pend_pc;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (resp_take) begin
                ir    <= imem_rdata;
                ir_pc <= pend_pc;
            end else begin
                ir_valid <= 1'b0;
            end
        end else if (resp_take) begin
            if (!ir_valid) begin
                ir       <= imem_rdata;
                ir_pc    <= pend_pc;
                ir_valid <= 1'b1;
            end else begin
                skid       <= imem_rdata;
                skid_pc    <= pend_pc;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (consume) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (ir_valid && stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by a random phase,
// all checked against a program-order reference model (expected request
// address, expected delivery PC, count of buffered instructions, epoch tags
// on in-flight reads to decide which responses survive a redirect).
// Perf counter checks are compiled in when IF_PERF_CNT_EN is defined.

module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] exp_req_pc;
    logic [31:0] exp_del_pc;
    logic [31:0] mem_addr;
    int          buffered;
    int          mem_cnt;
    int          epoch = 0;
    int          mem_epoch;
    int          n_cons;
    int          n_stall;
    int          lat_cfg = 1;
    bit          mem_busy;
    bit          mem_stale;
    bit          bad_data = 1'b0;
    bit          seen_bad = 1'b0;
    logic [31:0] delivered[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_del(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (delivered.size() > idx) ? delivered[idx] : 32'hxxxx_xxxx;
        chk(tag, obs, exp);
    endtask

    task automatic check_perf();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(n_cons));
        chk("perf_stall", perf_stall, 32'(n_stall));
`endif
    endtask

    task automatic model_init();
        buffered   = 0;
        exp_req_pc = RESET_PC;
        exp_del_pc = RESET_PC;
        mem_busy   = 1'b0;
        mem_stale  = 1'b0;
        mem_cnt    = 0;
        n_cons     = 0;
        n_stall    = 0;
        epoch++;
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, then advance
    // the model across the coming rising edge.
    task automatic step(input bit g, input bit s, input bit r, input logic [31:0] rpc);
        bit exp_req, rv, grant, consume, kept;
        int lat;
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        rv          = mem_busy && (mem_cnt == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? (bad_data ? 32'hDEAD_BEEF : (mem_addr ^ 32'hFFFF_FFFF)) : $urandom;
        imem_gnt    = g && !mem_stale;
        #1;
        exp_req = (!mem_busy || mem_stale) && (buffered < 2) && !r;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, exp_req_pc);
        chk("ir_valid", 32'(ir_valid), 32'(buffered > 0));
        if (buffered > 0) begin
            chk("ir_pc", ir_pc, exp_del_pc);
            chk("ir", ir, exp_del_pc ^ 32'hFFFF_FFFF);
        end
        if (ir_valid && ir == 32'hDEAD_BEEF) seen_bad = 1'b1;

        grant   = exp_req && imem_gnt;
        consume = (buffered > 0) && !s;
        kept    = rv && !mem_stale && (mem_epoch == epoch) && !r;
        if ((buffered > 0) && s) n_stall++;
        if (consume) begin
            delivered.push_back(ir_pc);
            exp_del_pc += 32'd4;
            n_cons++;
        end
        if (rv) begin
            mem_busy  = 1'b0;
            mem_stale = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (grant) begin
            mem_busy  = 1'b1;
            mem_addr  = exp_req_pc;
            mem_epoch = epoch;
            lat       = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(3, 1));
            mem_cnt   = lat - 1;
            exp_req_pc += 32'd4;
        end
        if (r) begin
            epoch++;
            buffered   = 0;
            exp_req_pc = rpc & 32'hFFFF_FFFC;
            exp_del_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            buffered = buffered + (kept ? 1 : 0) - (consume ? 1 : 0);
        end
    endtask

    task automatic do_reset(input bit stale);
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        #1;
        model_init();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        check_perf();
        @(negedge clk);
        rst_n = 1'b1;
        if (stale) begin
            // read granted before reset is still in the memory; it answers
            // on the second checked cycle after release
            mem_stale = 1'b1;
            mem_busy  = 1'b1;
            mem_cnt   = 1;
        end
        delivered.delete();
    endtask

    initial begin
        // streaming, 1-cycle memory
        do_reset(0);
        lat_cfg = 1;
        repeat (8) step(1, 0, 0, 32'd0);
        chk_del("t1_pc0", 0, 32'h3000);
        chk_del("t1_pc1", 1, 32'h3004);
        chk_del("t1_pc2", 2, 32'h3008);
        chk("t1_count", 32'(delivered.size()), 32'd3);
        check_perf();

        // stall for 6 cycles after the first instruction
        do_reset(0);
        step(1, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);
        repeat (6) step(1, 1, 0, 32'd0);
        chk("t2_hold_pc", ir_pc, 32'h3000);
        chk("t2_no_req", 32'(imem_req), 32'd0);
        repeat (4) step(1, 0, 0, 32'd0);
        chk_del("t2_pc0", 0, 32'h3000);
        chk_del("t2_pc1", 1, 32'h3004);
        chk_del("t2_pc2", 2, 32'h3008);
        check_perf();

        // redirect while WAIT, stale response 3 cycles later
        do_reset(0);
        lat_cfg = 4;
        step(1, 0, 0, 32'd0);
        step(0, 0, 1, 32'h0000_4003);
        bad_data = 1'b1;
        repeat (3) step(0, 0, 0, 32'd0);
        bad_data = 1'b0;
        lat_cfg  = 1;
        chk("t3_addr", imem_addr, 32'h4000);
        repeat (6) step(1, 0, 0, 32'd0);
        chk_del("t3_pc0", 0, 32'h4000);
        chk("t3_no_bad", 32'(seen_bad), 32'd0);

        // redirect together with rvalid
        do_reset(0);
        step(1, 0, 0, 32'd0);
        step(1, 0, 1, 32'h0000_5000);
        repeat (4) step(1, 0, 0, 32'd0);
        chk_del("t4_pc0", 0, 32'h5000);

        // redirect while skid full and stalled
        do_reset(0);
        step(1, 0, 0, 32'd0);
        step(1, 0, 0, 32'd0);
        step(1, 1, 0, 32'd0);
        step(1, 1, 0, 32'd0);
        step(1, 1, 1, 32'h0000_6001);
        step(1, 0, 0, 32'd0);
        chk("t4_flushed", 32'(ir_valid), 32'd0);
        repeat (3) step(1, 0, 0, 32'd0);
        chk_del("t4_skid_pc0", 0, 32'h6000);

        // address wrap
        do_reset(0);
        step(0, 0, 1, 32'hFFFF_FFFE);
        step(1, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0);
        chk("t5_wrap_addr", imem_addr, 32'h0000_0000);
        repeat (4) step(1, 0, 0, 32'd0);
        chk_del("t5_pc0", 0, 32'hFFFF_FFFC);
        chk_del("t5_pc1", 1, 32'h0000_0000);

        // random traffic
        do_reset(0);
        lat_cfg = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 20) == 0, $urandom);
        end
        check_perf();
        chk("rand_no_bad", 32'(seen_bad), 32'd0);

        // reset while a read is outstanding
        do_reset(0);
        lat_cfg = 3;
        step(1, 0, 0, 32'd0);
        do_reset(1);
        lat_cfg = 1;
        repeat (3) step(1, 0, 0, 32'd0);
        chk("t7_addr", imem_addr, RESET_PC);
        chk("t7_ir_valid", 32'(ir_valid), 32'd0);
        repeat (4) step(1, 0, 0, 32'd0);
        chk_del("t7_pc0", 0, RESET_PC);
        check_perf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
